// File: rtl/ysyx_trap_pkg.sv
// Shared constants for the machine-mode trap/return sequencer: CSR addresses,
// mstatus field positions and sequencer state encodings.
package ysyx_trap_pkg;

  // Machine-mode CSR addresses touched by the sequencer
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  // mstatus field positions
  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;
  localparam int unsigned MstatusMppLsb  = 11;
  localparam int unsigned MstatusMppMsb  = 12;

  // Machine privilege encoding written into MPP
  localparam logic [1:0] PrivM = 2'b11;

  // Sequencer states, kept as plain constants for legacy tooling
  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StTEpc    = 3'd1;
  localparam state_t StTCause  = 3'd2;
  localparam state_t StTStatus = 3'd3;
  localparam state_t StTVec    = 3'd4;
  localparam state_t StRStatus = 3'd5;
  localparam state_t StREpc    = 3'd6;
  localparam state_t StRedir   = 3'd7;

endpackage

// File: rtl/ysyx_mstatus_upd.sv
// Combinational mstatus transform for trap entry (MIE stacked into MPIE) and
// mret (MPIE restored into MIE). MPP is forced to M-mode in both directions.
module ysyx_mstatus_upd
  import ysyx_trap_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic        is_mret_i,
  output logic [31:0] new_o
);

  // Rewrite only MIE/MPIE/MPP; every other bit passes through untouched
  always_comb begin
    new_o = old_i;
    new_o[MstatusMppMsb:MstatusMppLsb] = PrivM;
    if (is_mret_i) begin
      new_o[MstatusMieBit]  = old_i[MstatusMpieBit];
      new_o[MstatusMpieBit] = 1'b1;
    end else begin
      new_o[MstatusMpieBit] = old_i[MstatusMieBit];
      new_o[MstatusMieBit]  = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer. Performs the CSR read-modify-write
// steps one CSR per cycle, then hands the new PC to fetch over valid/ready.
module ysyx_trap_ctrl
  import ysyx_trap_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE   = 32'd11,
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        is_illegal,
  input  logic [31:0] pc,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mstatus_new;
  logic        accept;

  // Trap flags are only looked at while idle
  assign accept = (state_q == StIdle) & inst_valid & (is_illegal | is_ecall | is_mret);
  assign busy   = (state_q != StIdle) | accept;

  ysyx_mstatus_upd u_mstatus_upd (
    .old_i     (csr_rdata),
    .is_mret_i (state_q == StRStatus),
    .new_o     (mstatus_new)
  );

  // Next-state and per-state CSR / redirect outputs
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    target_d       = target_q;
    csr_raddr      = 12'h000;
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d = pc;
          if (is_illegal) begin
            cause_d = ILLEGAL_CAUSE;
            state_d = StTEpc;
          end else if (is_ecall) begin
            cause_d = ECALL_CAUSE;
            state_d = StTEpc;
          end else begin
            cause_d = 32'h0;
            state_d = StRStatus;
          end
        end
      end
      StTEpc: begin
        csr_we    = 1'b1;
        csr_waddr = CsrMepc;
        csr_wdata = pc_q;
        state_d   = StTCause;
      end
      StTCause: begin
        csr_we    = 1'b1;
        csr_waddr = CsrMcause;
        csr_wdata = cause_q;
        state_d   = StTStatus;
      end
      StTStatus: begin
        csr_raddr = CsrMstatus;
        csr_we    = 1'b1;
        csr_waddr = CsrMstatus;
        csr_wdata = mstatus_new;
        state_d   = StTVec;
      end
      StTVec: begin
        // Direct mode only: the MODE bits are dropped
        csr_raddr = CsrMtvec;
        target_d  = {csr_rdata[31:2], 2'b00};
        state_d   = StRedir;
      end
      StRStatus: begin
        csr_raddr = CsrMstatus;
        csr_we    = 1'b1;
        csr_waddr = CsrMstatus;
        csr_wdata = mstatus_new;
        state_d   = StREpc;
      end
      StREpc: begin
        csr_raddr = CsrMepc;
        target_d  = {csr_rdata[31:2], 2'b00};
        state_d   = StRedir;
      end
      StRedir: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= 32'h0;
      cause_q  <= 32'h0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

endmodule

// File: doc/ysyx_trap_ctrl.md
YSYX_TRAP_CTRL -- requirements
Module: ysyx_trap_ctrl

Interface
REQ-001 Parameter ECALL_CAUSE, default 32'd11, mcause value written for ecall (environment call from M-mode).
REQ-002 Parameter ILLEGAL_CAUSE, default 32'd2, mcause value written for illegal instruction.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 inst_valid  in  1  current instruction valid, held stable by core while busy=1.
REQ-006 is_ecall / is_mret / is_illegal  in  1 each  decoded trap class of current instruction.
REQ-007 pc  in  32  PC of current instruction.
REQ-008 csr_raddr  out  12  CSR read address; csr_rdata  in  32  combinational read data, same cycle.
REQ-009 csr_we  out  1  CSR write strobe; csr_waddr  out  12; csr_wdata  out  32.
REQ-010 busy  out  1  core must stall fetch/commit while high.
REQ-011 redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  valid/ready PC-redirect handshake to fetch.

Function
REQ-012 States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, R_STATUS, R_EPC, REDIR.
REQ-013 In IDLE, inst_valid with any trap flag is accepted; priority is_illegal > is_ecall > is_mret; pc and cause latched on accept.
REQ-014 Accepting illegal/ecall -> T_EPC; accepting mret -> R_STATUS; no trap flag -> remain IDLE, no CSR activity.
REQ-015 T_EPC: csr_we=1, waddr 12'h341, wdata = latched pc; -> T_CAUSE.
REQ-016 T_CAUSE: csr_we=1, waddr 12'h342, wdata = ILLEGAL_CAUSE or ECALL_CAUSE; -> T_STATUS.
REQ-017 T_STATUS: raddr 12'h300, csr_we=1, waddr 12'h300, wdata = rdata with bit7(MPIE)=rdata[3], bit3(MIE)=0, bits12:11(MPP)=2'b11, other bits unchanged; -> T_VEC.
REQ-018 T_VEC: raddr 12'h305, target latched as {rdata[31:2],2'b00} (direct mode only); no write; -> REDIR.
REQ-019 R_STATUS: raddr/waddr 12'h300, csr_we=1, wdata = rdata with bit3=rdata[7], bit7=1, bits12:11=2'b11; -> R_EPC.
REQ-020 R_EPC: raddr 12'h341, target latched as {rdata[31:2],2'b00}; no write; -> REDIR.
REQ-021 REDIR: redirect_valid=1, redirect_pc=target; leave to IDLE on the cycle redirect_valid&redirect_ready; otherwise hold, outputs stable.
REQ-022 csr_we is high only in T_EPC, T_CAUSE, T_STATUS, R_STATUS; exactly one CSR write per such state.
REQ-023 busy = (state != IDLE) | (state==IDLE & inst_valid & any trap flag); combinational.
REQ-024 Latency: trap accepted cycle 0 -> redirect_valid first high cycle 4; mret accepted cycle 0 -> redirect_valid first high cycle 2.
REQ-025 Trap flags and inst_valid are ignored outside IDLE; a trap in REDIR is serviced only after return to IDLE.
REQ-026 Back-to-back: trap presented in the cycle after REDIR handshake is accepted normally.
REQ-027 csr_raddr = 12'h000 and csr_waddr/csr_wdata = 0 in states that make no access.

Reset
REQ-028 rst_n=0 at a posedge: state=IDLE, latched pc/cause/target=0; outputs csr_we=0, redirect_valid=0, redirect_pc=0, busy=0 (when no trap request).
REQ-029 Reset mid-sequence aborts with no further CSR writes; partially written CSRs are not rolled back.

Structure
REQ-030 Package ysyx_trap_pkg holds CSR address constants (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342), mstatus bit positions, and the state enum.
REQ-031 One sub-module ysyx_mstatus_upd: combinational mstatus transform, input old value + trap/mret select, output new value.

Verification
REQ-032 ecall at pc=0x80000010, mstatus=0x8, mtvec=0x80000101 -> writes mepc=0x80000010, mcause=11, mstatus=0x1880; redirect_pc=0x80000100 at cycle 4.
REQ-033 mret with mepc=0x80000014, mstatus=0x1880 -> mstatus write 0x1888; redirect_pc=0x80000014 at cycle 2.
REQ-034 is_illegal and is_ecall both set -> mcause=2, single sequence only.
REQ-035 redirect_ready low 3 cycles in REDIR -> redirect_valid/pc held stable, busy=1, no CSR writes; leave on handshake.
REQ-036 rst_n=0 during T_CAUSE -> next cycle IDLE, csr_we=0, no mstatus write ever issued.
REQ-037 inst_valid with no trap flag for 10 cycles -> busy=0, csr_we=0, redirect_valid=0 throughout.
